// File: rtl/alu_rs_if.sv
// Issue, result-broadcast and dispatch bundle between the issue stage, the
// ALU reservation station and the ALU execution unit.
interface alu_rs_if #(
  parameter int unsigned ROB_W = 4
) ();

  // issue request from the decoder
  logic             issue_valid;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic             issue_funct7;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [ROB_W-1:0] issue_rob_pos;
  logic             issue_q1_rdy;
  logic [31:0]      issue_v1;
  logic [ROB_W-1:0] issue_q1;
  logic             issue_q2_rdy;
  logic [31:0]      issue_v2;
  logic [ROB_W-1:0] issue_q2;

  // result broadcasts
  logic             alu_res_done;
  logic [ROB_W-1:0] alu_res_rob_pos;
  logic [31:0]      alu_res_val;
  logic             lsb_res_done;
  logic [ROB_W-1:0] lsb_res_rob_pos;
  logic [31:0]      lsb_res_val;

  // status and dispatch to the ALU
  logic             rs_full;
  logic             alu_en;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7;
  logic [31:0]      val1;
  logic [31:0]      val2;
  logic [31:0]      imm;
  logic [31:0]      pc;
  logic [ROB_W-1:0] rob_pos;

  modport slave (
    input  issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_imm,
           issue_pc, issue_rob_pos, issue_q1_rdy, issue_v1, issue_q1,
           issue_q2_rdy, issue_v2, issue_q2,
           alu_res_done, alu_res_rob_pos, alu_res_val,
           lsb_res_done, lsb_res_rob_pos, lsb_res_val,
    output rs_full, alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos
  );

  modport master (
    output issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_imm,
           issue_pc, issue_rob_pos, issue_q1_rdy, issue_v1, issue_q1,
           issue_q2_rdy, issue_v2, issue_q2,
           alu_res_done, alu_res_rob_pos, alu_res_val,
           lsb_res_done, lsb_res_rob_pos, lsb_res_val,
    input  rs_full, alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos
  );

endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued micro-ops, wakes operands from the
// ALU/LSB broadcasts and dispatches the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rdy,
  input  logic     rollback,
  alu_rs_if.slave  bus
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] rob_pos;
    logic             q1_rdy;
    logic [XLEN-1:0]  v1;
    logic [ROB_W-1:0] q1;
    logic             q2_rdy;
    logic [XLEN-1:0]  v2;
    logic [ROB_W-1:0] q2;
  } entry_t;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [XLEN-1:0]  val1;
    logic [XLEN-1:0]  val2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] rob_pos;
  } disp_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic               alu_en_q, alu_en_d;
  disp_t              out_q, out_d;

  logic               sel_ok, free_ok;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  entry_t             new_ent;

  // Operand capture: ALU broadcast wins over LSB when both match.
  function automatic logic [XLEN:0] capture(
    input logic             r,
    input logic [XLEN-1:0]  v,
    input logic [ROB_W-1:0] q,
    input logic             a_done,
    input logic [ROB_W-1:0] a_pos,
    input logic [XLEN-1:0]  a_val,
    input logic             l_done,
    input logic [ROB_W-1:0] l_pos,
    input logic [XLEN-1:0]  l_val
  );
    logic [XLEN:0] res;
    res = {r, v};
    if (!r) begin
      if (a_done && (a_pos == q))      res = {1'b1, a_val};
      else if (l_done && (l_pos == q)) res = {1'b1, l_val};
    end
    return res;
  endfunction

  // Lowest-index ready entry and lowest-index free slot, from registered state.
  always_comb begin
    sel_ok   = 1'b0;
    sel_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && ent_q[i].q1_rdy && ent_q[i].q2_rdy) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_ok  = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Issued entry with same-cycle broadcast bypass applied.
  always_comb begin
    new_ent         = '0;
    new_ent.opcode  = bus.issue_opcode;
    new_ent.funct3  = bus.issue_funct3;
    new_ent.funct7  = bus.issue_funct7;
    new_ent.imm     = bus.issue_imm;
    new_ent.pc      = bus.issue_pc;
    new_ent.rob_pos = bus.issue_rob_pos;
    new_ent.q1      = bus.issue_q1;
    new_ent.q2      = bus.issue_q2;
    {new_ent.q1_rdy, new_ent.v1} = capture(bus.issue_q1_rdy, bus.issue_v1, bus.issue_q1,
                                           bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_val,
                                           bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
    {new_ent.q2_rdy, new_ent.v2} = capture(bus.issue_q2_rdy, bus.issue_v2, bus.issue_q2,
                                           bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_val,
                                           bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
  end

  // Next state: wakeup, select, then issue into a slot free at cycle start.
  always_comb begin
    ent_d    = ent_q;
    busy_d   = busy_q;
    alu_en_d = 1'b0;
    out_d    = out_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        {ent_d[i].q1_rdy, ent_d[i].v1} = capture(ent_q[i].q1_rdy, ent_q[i].v1, ent_q[i].q1,
                                                 bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_val,
                                                 bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
        {ent_d[i].q2_rdy, ent_d[i].v2} = capture(ent_q[i].q2_rdy, ent_q[i].v2, ent_q[i].q2,
                                                 bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_val,
                                                 bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
      end
    end

    if (sel_ok) begin
      alu_en_d        = 1'b1;
      busy_d[sel_idx] = 1'b0;
      out_d.opcode    = ent_q[sel_idx].opcode;
      out_d.funct3    = ent_q[sel_idx].funct3;
      out_d.funct7    = ent_q[sel_idx].funct7;
      out_d.val1      = ent_q[sel_idx].v1;
      out_d.val2      = ent_q[sel_idx].v2;
      out_d.imm       = ent_q[sel_idx].imm;
      out_d.pc        = ent_q[sel_idx].pc;
      out_d.rob_pos   = ent_q[sel_idx].rob_pos;
    end

    if (bus.issue_valid && free_ok) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = new_ent;
    end
  end

  // State registers: reset beats rdy; rollback clears like reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= '0;
      alu_en_q <= 1'b0;
      out_q    <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy_q   <= '0;
        alu_en_q <= 1'b0;
        out_q    <= '0;
        for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      end else begin
        busy_q   <= busy_d;
        alu_en_q <= alu_en_d;
        out_q    <= out_d;
        for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      end
    end
  end

  assign bus.rs_full = &busy_q;
  assign bus.alu_en  = alu_en_q;
  assign bus.opcode  = out_q.opcode;
  assign bus.funct3  = out_q.funct3;
  assign bus.funct7  = out_q.funct7;
  assign bus.val1    = out_q.val1;
  assign bus.val2    = out_q.val2;
  assign bus.imm     = out_q.imm;
  assign bus.pc      = out_q.pc;
  assign bus.rob_pos = out_q.rob_pos;

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station for the out-of-order core. It buffers integer, branch and jump micro-ops issued by the decoder, tracks their source operands by ROB tag, and captures operand values from the ALU and load/store result broadcasts. Each cycle it sends at most one ready entry to the ALU execution unit as a registered `alu_en` pulse. It sits between the issue stage and the ALU; `rollback` flushes it.

## Interface
- `RS_SIZE`, 16: number of entries, a power of two.
- `ROB_W`, 4: ROB tag width, matching `ROB_WID`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `rdy` in 1: global enable. When low, all state holds.
- `rollback` in 1: mispredict flush.
- `issue_valid` in 1: issue request this cycle.
- `issue_opcode` in 7, `issue_funct3` in 3, `issue_funct7` in 1: decoded fields.
- `issue_imm` in 32, `issue_pc` in 32, `issue_rob_pos` in ROB_W: payload.
- `issue_q1_rdy` in 1, `issue_v1` in 32, `issue_q1` in ROB_W: rs1 readiness, value, and producer tag.
- `issue_q2_rdy` in 1, `issue_v2` in 32, `issue_q2` in ROB_W: same fields for rs2.
- `alu_res_done` in 1, `alu_res_rob_pos` in ROB_W, `alu_res_val` in 32: ALU broadcast.
- `lsb_res_done` in 1, `lsb_res_rob_pos` in ROB_W, `lsb_res_val` in 32: load/store broadcast.
- `rs_full` out 1: all entries valid. Combinational from registered state.
- `alu_en` out 1: dispatch pulse to the ALU.
- `opcode` out 7, `funct3` out 3, `funct7` out 1: fields for the dispatched entry.
- `val1` out 32, `val2` out 32, `imm` out 32, `pc` out 32: operands for the dispatched entry.
- `rob_pos` out ROB_W: ROB tag of the dispatched entry.

## Operation
- Entry state: `busy`, payload, `q1_rdy`/`v1`/`q1`, `q2_rdy`/`v2`/`q2`.
- Operands an instruction does not use (rs2 for `OPCODE_CALI`, `JALR`, `LUI`, `AUIPC`, `JAL`; rs1 for `LUI`, `AUIPC`, `JAL`) arrive with the ready bit set from issue. The RS never decodes the opcode for readiness.
- Issue: if `issue_valid && !rs_full`, the request is written into the lowest-index non-busy entry. Issue while `rs_full` is a protocol violation: the request is dropped and state is unchanged.
- Issue bypass: if an issued operand is not ready and its tag matches a broadcast in the same cycle, the entry is written ready with the broadcast value. If both broadcasts match, ALU has priority; the bench never drives this case.
- Wakeup: every busy entry with `!qN_rdy` and `qN == *_res_rob_pos` under a valid `*_res_done` sets `qN_rdy` and latches the value. Both operands may wake in the same cycle.
- Select: among entries that were busy with both ready bits set in the registered state at the start of the cycle, the lowest index is chosen. At the edge, its fields are registered onto the outputs, `alu_en` is set to 1, and the entry's `busy` is cleared. If no entry is ready, `alu_en` is set to 0; the other outputs hold.
- A slot freed by select is not reusable by issue in the same cycle.
- Priority at each edge, when `rdy` is high: `!rst_n` first, then `rollback`, then normal issue/wakeup/select.

## Timing
- Reset (`!rst_n`, sampled at the edge): all `busy`=0; `alu_en`=0; `opcode`, `funct3`, `funct7`, `val1`, `val2`, `imm`, `pc`, `rob_pos` = 0. Reset is applied regardless of `rdy`.
- Rollback (`rollback`=1 with `rdy`=1): same clearing as reset. Issue and wakeup in that cycle are discarded.
- `rdy`=0: every register, including `alu_en`, holds.
- Latency: issue with both operands ready at edge t leads to `alu_en`=1 during cycle t+1..t+2, which leads to the ALU `res_done` after edge t+2.
- Wakeup: a broadcast at edge t makes the entry selectable at edge t+1.
- `alu_en` is a one-cycle pulse per dispatched entry. Back-to-back dispatch of different entries on consecutive cycles is allowed.
- `rs_full` updates in the cycle after the edge that fills or frees the last slot.

## Test plan
- Ready issue: reset, then issue ADD (`opcode`=0110011, `v1`=5, `v2`=7, both ready, `rob_pos`=3). Expect `alu_en`=1 exactly one cycle later with `val1`=5, `val2`=7, `rob_pos`=3, then `alu_en`=0.
- Wakeup: issue with `q1_rdy`=0, `q1`=9. Two cycles later, drive `alu_res_done`=1, `alu_res_rob_pos`=9, `alu_res_val`=0x1234. Expect no dispatch before the broadcast, then `alu_en`=1 one cycle after the broadcast edge with `val1`=0x1234.
- Issue bypass: issue with `q2`=4 not ready while `lsb_res_done`=1, `lsb_res_rob_pos`=4, `lsb_res_val`=0xAA in the same cycle. Expect dispatch next cycle with `val2`=0xAA.
- Full: issue 16 entries, all blocked on tag 15. Expect `rs_full`=1; a 17th issue is ignored. Broadcast tag 15. Expect 16 consecutive `alu_en` pulses in index order, and `rs_full` falls after the first dispatch.
- Rollback: with 3 pending entries and one ready, assert `rollback` together with `issue_valid`. Expect `alu_en`=0, all entries cleared, `rs_full`=0, and no later dispatch.
- Hold and reset: drop `rdy` while `alu_en`=1. Expect outputs frozen until `rdy` returns. Then assert `rst_n`=0 with `rdy`=0. Expect all outputs 0 on that edge.
